// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: small circular instruction queue between IF and ID.
// Holds {instr, pc_plus_4} pairs, presents the oldest entry to decode, and
// drives ready_f for the hazard unit's fetch enable.
// Optional build macro FDQ_PERF_EN adds saturating full_cycles/flush_count
// performance counters.
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           instr_f,
    input  logic [WIDTH-1:0]           pc_plus_4_f,
    input  logic                       valid_f,
    output logic                       ready_f,
    output logic [WIDTH-1:0]           instr_d,
    output logic [WIDTH-1:0]           pc_plus_4_d,
    output logic                       valid_d,
    input  logic                       stall_d,
    input  logic                       flush_d,
`ifdef FDQ_PERF_EN
    output logic [31:0]                full_cycles,
    output logic [31:0]                flush_count,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // ready_f depends only on the registered count so it never loops back
    // through the hazard unit via stall_d.
    assign ready_f = (count_q != FULL_CNT);
    assign valid_d = (count_q != '0);
    assign push    = valid_f & ready_f & ~flush_d;
    assign pop     = valid_d & ~stall_d & ~flush_d;
    assign count   = count_q;

    // Head entry to decode; forced to NOP/zero when empty so stale storage
    // never leaks out.
    assign instr_d     = valid_d ? instr_mem_q[head_q] : '0;
    assign pc_plus_4_d = valid_d ? pc_mem_q[head_q]    : '0;

    // Next-state for pointers and occupancy; flush discards any push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_d) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[tail_q] <= instr_f;
            pc_mem_q[tail_q]    <= pc_plus_4_f;
        end
    end

`ifdef FDQ_PERF_EN
    logic [31:0] full_cycles_q;
    logic [31:0] flush_count_q;

    assign full_cycles = full_cycles_q;
    assign flush_count = flush_count_q;

    // Saturating counters: cycles fetch was blocked by a full queue, and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_cycles_q <= '0;
            flush_count_q <= '0;
        end else begin
            if ((count_q == FULL_CNT) && valid_f && (full_cycles_q != '1))
                full_cycles_q <= full_cycles_q + 32'd1;
            if (flush_d && (flush_count_q != '1))
                flush_count_q <= flush_count_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized self-checking bench for fetch_decode_queue, compared against a
// queue-based reference model. Perf counters are checked when built with
// FDQ_PERF_EN.
module tb_fetch_decode_queue;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] instr_f, pc_plus_4_f;
    logic             valid_f, stall_d, flush_d;
    logic             ready_f, valid_d;
    logic [WIDTH-1:0] instr_d, pc_plus_4_d;
    logic [$clog2(DEPTH):0] count;
`ifdef FDQ_PERF_EN
    logic [31:0] full_cycles, flush_count;
`endif

    fetch_decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_f     (instr_f),
        .pc_plus_4_f (pc_plus_4_f),
        .valid_f     (valid_f),
        .ready_f     (ready_f),
        .instr_d     (instr_d),
        .pc_plus_4_d (pc_plus_4_d),
        .valid_d     (valid_d),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
`ifdef FDQ_PERF_EN
        .full_cycles (full_cycles),
        .flush_count (flush_count),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: FIFO of {instr, pc_plus_4}
    logic [63:0] mq[$];
    longint      m_full_cyc  = 0;
    longint      m_flush_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        int sz;
        sz = mq.size();
        check("count",   64'(count),   64'(sz));
        check("valid_d", 64'(valid_d), 64'(sz != 0));
        check("ready_f", 64'(ready_f), 64'(sz != DEPTH));
        check("instr_d", 64'(instr_d), (sz != 0) ? 64'(mq[0][63:32]) : 64'd0);
        check("pc4_d",   64'(pc_plus_4_d), (sz != 0) ? 64'(mq[0][31:0]) : 64'd0);
`ifdef FDQ_PERF_EN
        check("full_cycles", 64'(full_cycles), 64'(m_full_cyc));
        check("flush_count", 64'(flush_count), 64'(m_flush_cnt));
`endif
    endtask

    // One clock: drive inputs, advance model across the edge, then check.
    task automatic cycle(input logic r, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic s, input logic f,
                         output logic acc);
        logic do_pop;
        reset = r; valid_f = v; instr_f = i; pc_plus_4_f = p; stall_d = s; flush_d = f;
        acc    = !r && !f && v && (mq.size() != DEPTH);
        do_pop = !r && !f && !s && (mq.size() != 0);
        if (r) begin
            m_full_cyc = 0; m_flush_cnt = 0;
        end else begin
            if (mq.size() == DEPTH && v) m_full_cyc++;
            if (f) m_flush_cnt++;
        end
        @(posedge clk);
        if (r || f) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (acc) mq.push_back({i, p});
        end
        #1 check_all();
    endtask

    // Offer a word until accepted (fetch holds while ready_f is low).
    task automatic fetch_word(input logic [31:0] i, input logic [31:0] p, input logic s);
        logic acc;
        int   k;
        acc = 1'b0;
        for (k = 0; k < 50 && !acc; k++) cycle(1'b0, 1'b1, i, p, s, 1'b0, acc);
        check("fetch_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        logic        acc;
        logic [31:0] pend_i, pend_p;

        reset = 1'b1; valid_f = 1'b0; instr_f = '0; pc_plus_4_f = '0;
        stall_d = 1'b0; flush_d = 1'b0;

        // reset then idle
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        idle(2);

        // streaming: one word per cycle, occupancy holds at 1
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 32'h20080005, 32'h4, 1'b0, 1'b0, acc);
        check("stream_count", 64'(count), 64'd1);
        idle(2);

        // fill under stall, third word held, then release
        cycle(1'b0, 1'b1, 32'hAAAA0001, 32'h100, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b1, 32'hAAAA0002, 32'h104, 1'b1, 1'b0, acc);
        check("full_ready", 64'(ready_f), 64'd0);
        cycle(1'b0, 1'b1, 32'hAAAA0003, 32'h108, 1'b1, 1'b0, acc);
        check("held_rejected", 64'(acc), 64'd0);
        // full with simultaneous pop: rejected, count drops to 1
        cycle(1'b0, 1'b1, 32'hAAAA0003, 32'h108, 1'b0, 1'b0, acc);
        check("full_pop_rej", 64'(acc), 64'd0);
        check("full_pop_cnt", 64'(count), 64'd1);
        check("full_pop_head", 64'(instr_d), 64'h00000000_AAAA0002);
        fetch_word(32'hAAAA0003, 32'h108, 1'b0);
        idle(3);

        // flush mid-operation with a word offered
        cycle(1'b0, 1'b1, 32'hAAAA0011, 32'h200, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b1, 32'hAAAA0012, 32'h204, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b1, 32'hBBBB0000, 32'h208, 1'b0, 1'b1, acc);
        check("flush_instr", 64'(instr_d), 64'd0);
        cycle(1'b0, 1'b1, 32'hCCCC0000, 32'h300, 1'b0, 1'b0, acc);
        check("post_flush", 64'(instr_d), 64'h00000000_CCCC0000);
        idle(2);

        // wrap-around: push/pop pairs interleaved with 2-cycle stalls
        for (int k = 0; k < 10; k++) begin
            fetch_word(32'hD000_0000 + 32'(k), 32'h400 + 32'(4*k), (k % 3) == 1);
            if ((k % 3) == 1) begin
                cycle(1'b0, 1'b1, 32'hD000_0100 + 32'(k), 32'h500, 1'b1, 1'b0, acc);
                if (!acc) fetch_word(32'hD000_0100 + 32'(k), 32'h500, 1'b0);
            end
        end
        idle(3);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

        // randomized traffic
        pend_i = $urandom; pend_p = $urandom;
        for (int k = 0; k < 3000; k++) begin
            logic r, v, s, f;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 24) == 0);
            cycle(r, v, pend_i, pend_p, s, f, acc);
            if (acc) begin pend_i = $urandom; pend_p = $urandom; end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
